// File: rtl/next_ip_unit.sv
// Fetch-stage next-IP generator: owns IP_f, direct-mapped BTB lookup, redirect/stall priority.
// Optional NIP_BTB_BYPASS_EN forwards a same-cycle BTB write to the lookup.
module next_ip_unit #(
    parameter int unsigned BTB_IDX  = 6,
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        stall,
    input  logic        prediction,
    input  logic        redirect,
    input  logic [15:0] redirectIP,
    input  logic        updateEn,
    input  logic [15:0] updateIP,
    input  logic [15:0] updateTarget,
    output logic [15:0] IP_f,
    output logic        btbHit,
    output logic        predTaken_f,
    output logic [15:0] predNextIP
);

    localparam int unsigned Entries = 1 << BTB_IDX;
    localparam int unsigned TagW    = 16 - BTB_IDX;

    logic [15:0]        r_ip;
    logic [Entries-1:0] r_valid;
    logic [TagW-1:0]    r_tag    [Entries];
    logic [15:0]        r_target [Entries];

    logic [BTB_IDX-1:0] w_idx;
    logic [BTB_IDX-1:0] w_upd_idx;
    logic               w_arr_hit;
    logic               w_hit;
    logic [15:0]        w_target;

    assign w_idx     = r_ip[BTB_IDX-1:0];
    assign w_upd_idx = updateIP[BTB_IDX-1:0];
    assign w_arr_hit = r_valid[w_idx] && (r_tag[w_idx] == r_ip[15:BTB_IDX]);

`ifdef NIP_BTB_BYPASS_EN
    logic w_bypass;
    assign w_bypass = updateEn && !reset && (updateIP == r_ip);
    assign w_hit    = w_bypass || w_arr_hit;
    assign w_target = w_bypass ? updateTarget : r_target[w_idx];
`else
    assign w_hit    = w_arr_hit;
    assign w_target = r_target[w_idx];
`endif

    always_comb begin
        IP_f        = r_ip;
        btbHit      = w_hit;
        predTaken_f = w_hit && prediction;
        predNextIP  = predTaken_f ? w_target : r_ip + 16'd1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_ip <= RESET_IP;
        end else if (redirect) begin
            r_ip <= redirectIP;
        end else if (!stall) begin
            r_ip <= predNextIP;
        end
    end

    // Tag/target need no reset; only the valid bits define an empty BTB.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_valid <= '0;
        end else if (updateEn) begin
            r_valid[w_upd_idx]  <= 1'b1;
            r_tag[w_upd_idx]    <= updateIP[15:BTB_IDX];
            r_target[w_upd_idx] <= updateTarget;
        end
    end

endmodule

// File: tb/tb_next_ip_unit.sv
// Scoreboard bench for next_ip_unit: stimulus pushes model-predicted outputs, a negedge monitor
// pops and compares. A second instance with RESET_IP=16'hFFFE checks wrap after reset.
module tb_next_ip_unit;

    localparam int NENT = 64;

    logic        clk = 1'b0;
    logic        reset, stall, prediction, redirect, updateEn;
    logic [15:0] redirectIP, updateIP, updateTarget;
    logic [15:0] IP_f, predNextIP;
    logic        btbHit, predTaken_f;
    logic [15:0] IP_f2, predNextIP2;
    logic        btbHit2, predTaken_f2;

    always #5 clk = ~clk;

    next_ip_unit #(.BTB_IDX(6), .RESET_IP(16'h0000)) dut (
        .CLOCK_50(clk), .reset(reset), .stall(stall), .prediction(prediction),
        .redirect(redirect), .redirectIP(redirectIP), .updateEn(updateEn),
        .updateIP(updateIP), .updateTarget(updateTarget), .IP_f(IP_f), .btbHit(btbHit),
        .predTaken_f(predTaken_f), .predNextIP(predNextIP)
    );

    next_ip_unit #(.BTB_IDX(6), .RESET_IP(16'hFFFE)) dut2 (
        .CLOCK_50(clk), .reset(reset), .stall(1'b0), .prediction(1'b0),
        .redirect(1'b0), .redirectIP(16'h0000), .updateEn(1'b0),
        .updateIP(16'h0000), .updateTarget(16'h0000), .IP_f(IP_f2), .btbHit(btbHit2),
        .predTaken_f(predTaken_f2), .predNextIP(predNextIP2)
    );

    typedef struct {
        logic [15:0] ip;
        logic        hit;
        logic        taken;
        logic [15:0] pnip;
        logic [15:0] ip2;
        logic        hit2;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Reference model: BTB stores the full trained address per slot.
    logic [15:0] m_ip, m_ip2;
    bit          m_valid [NENT];
    logic [15:0] m_addr  [NENT];
    logic [15:0] m_tgt   [NENT];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("IP_f", IP_f, e.ip);
            chk("btbHit", {15'd0, btbHit}, {15'd0, e.hit});
            chk("predTaken_f", {15'd0, predTaken_f}, {15'd0, e.taken});
            chk("predNextIP", predNextIP, e.pnip);
            chk("IP_f_wrap", IP_f2, e.ip2);
            chk("btbHit_wrap", {15'd0, btbHit2}, {15'd0, e.hit2});
        end
    end

    task automatic cyc(input logic rst, input logic stl, input logic pred, input logic rd,
                       input logic [15:0] rdip, input logic ue, input logic [15:0] uip,
                       input logic [15:0] utgt);
        exp_t        e;
        int          idx;
        logic        hit;
        logic [15:0] tgt;
        @(posedge clk);
        #1;
        reset = rst; stall = stl; prediction = pred; redirect = rd;
        redirectIP = rdip; updateEn = ue; updateIP = uip; updateTarget = utgt;
        idx = int'(m_ip) % NENT;
        hit = m_valid[idx] && (m_addr[idx] == m_ip);
        tgt = m_tgt[idx];
`ifdef NIP_BTB_BYPASS_EN
        if (ue && uip == m_ip) begin
            hit = 1'b1;
            tgt = utgt;
        end
`endif
        e.ip    = m_ip;
        e.hit   = hit;
        e.taken = hit && pred;
        e.pnip  = (hit && pred) ? tgt : m_ip + 16'd1;
        e.ip2   = m_ip2;
        e.hit2  = 1'b0;
        // Pre-reset state is undefined, so reset cycles carry no expectation.
        if (!rst) exp_q.push_back(e);
        if (rst) begin
            m_ip  = 16'h0000;
            m_ip2 = 16'hFFFE;
            for (int i = 0; i < NENT; i++) m_valid[i] = 1'b0;
        end else begin
            if (rd)        m_ip = rdip;
            else if (!stl) m_ip = e.pnip;
            m_ip2 = m_ip2 + 16'd1;
            if (ue) begin
                m_valid[int'(uip) % NENT] = 1'b1;
                m_addr[int'(uip) % NENT]  = uip;
                m_tgt[int'(uip) % NENT]   = utgt;
            end
        end
    endtask

    task automatic go(input logic pred);
        cyc(1'b0, 1'b0, pred, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic jump(input logic [15:0] a);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, a, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic train(input logic [15:0] a, input logic [15:0] t);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, a, t);
    endtask

    initial begin
        logic [15:0] pool [8];
        pool = '{16'h0005, 16'h0045, 16'h0010, 16'h0020, 16'h0085, 16'h0007, 16'hFFFF, 16'h0046};
        m_ip = 16'h0; m_ip2 = 16'h0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        repeat (4) go(1'b1);
        // Train 5->0x40, then taken and not-taken lookups.
        train(16'h0005, 16'h0040);
        jump(16'h0005);
        go(1'b1);
        go(1'b1);
        jump(16'h0005);
        go(1'b0);
        go(1'b0);
        // Alias 0x45 replaces slot 5.
        train(16'h0045, 16'h0080);
        jump(16'h0005);
        go(1'b1);
        jump(16'h0045);
        go(1'b1);
        go(1'b1);
        // Stall hold, then redirect overrides stall.
        jump(16'h0010);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0, 16'h0);
        go(1'b0);
        // Reset wins over redirect and update.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h0200, 1'b1, 16'h0077, 16'h0099);
        go(1'b0);
        jump(16'h0077);
        go(1'b1);
        go(1'b1);
        // Same-cycle update at the current IP.
        jump(16'h0020);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0020, 16'h0030);
        go(1'b1);
        go(1'b1);
        // Random traffic over a small address pool so hits and aliases recur.
        for (int n = 0; n < 500; n++) begin
            logic        r_rst, r_stl, r_pred, r_rd, r_ue;
            logic [15:0] r_rdip, r_uip, r_tgt;
            r_rst  = ($urandom_range(63) == 0);
            r_stl  = ($urandom_range(3) == 0);
            r_pred = $urandom_range(1) == 1;
            r_rd   = ($urandom_range(7) == 0);
            r_rdip = pool[$urandom_range(7)];
            r_ue   = ($urandom_range(3) == 0);
            r_uip  = ($urandom_range(1) == 1) ? m_ip : pool[$urandom_range(7)];
            r_tgt  = pool[$urandom_range(7)] + 16'($urandom_range(3));
            cyc(r_rst, r_stl, r_pred, r_rd, r_rdip, r_ue, r_uip, r_tgt);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/next_ip_unit.md
# next_ip_unit

Fetch-stage next-instruction-pointer generator sitting directly upstream of the branch predictor. Owns the `IP_f` register, performs a direct-mapped branch-target-buffer (BTB) lookup on `IP_f` each cycle, and combines the hit with the predictor's combinational `prediction` to choose the next fetch address. Execute-stage redirects on mispredict and BTB training updates come back into this block.

## Interface
Parameters:
- `BTB_IDX`, default 6: log2 of BTB entries (64); index = `IP[BTB_IDX-1:0]`, tag = `IP[15:BTB_IDX]`.
- `RESET_IP`, default 16'h0000: fetch address after reset.

Ports:
- `CLOCK_50` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold `IP_f` (decode not accepting).
- `prediction` in 1: taken/not-taken for current `IP_f`, combinational from the predictor.
- `redirect` in 1: execute detected mispredict.
- `redirectIP` in 16: correct next fetch address.
- `updateEn` in 1: train BTB with a resolved taken jump.
- `updateIP` in 16: address of the jump.
- `updateTarget` in 16: its target.
- `IP_f` out 16: current fetch address (feeds predictor and instruction memory).
- `btbHit` out 1: valid entry with matching tag for `IP_f`.
- `predTaken_f` out 1: `btbHit && prediction`.
- `predNextIP` out 16: address fetched after `IP_f` absent redirect; travels down the pipe as the expected IP.

## Operation
- BTB: 2^BTB_IDX entries of {valid, tag[15-BTB_IDX:0], target[15:0]}; read combinationally at index `IP_f[BTB_IDX-1:0]`.
- `btbHit` = valid[idx] && tag[idx] == `IP_f[15:BTB_IDX]`.
- `predNextIP` = `predTaken_f` ? target[idx] : `IP_f` + 1 (16-bit, wraps 16'hFFFF -> 16'h0000; word-addressed).
- Next `IP_f`, priority order: `reset` -> `RESET_IP`; `redirect` -> `redirectIP` (overrides `stall`); `stall` -> hold; else `predNextIP`.
- BTB write on `updateEn`: entry at `updateIP[BTB_IDX-1:0]` <= {1, `updateIP[15:BTB_IDX]`, `updateTarget`}; unconditional overwrite of any existing entry (aliasing replaces). Writes proceed regardless of `stall`/`redirect`.
- No invalidate on not-taken; a stale entry is corrected only via the predictor saying not-taken or via redirect.
- Reset clears all valid bits (synchronous, one cycle); tag/target contents don't-care. `updateEn` in a reset cycle is ignored.

## Timing
- Reset values: `IP_f` = `RESET_IP`; `btbHit` = 0, `predTaken_f` = 0, `predNextIP` = `RESET_IP`+1 (BTB empty).
- Lookup latency 0: `btbHit`/`predNextIP` valid in the same cycle as `IP_f`.
- Redirect latency 1: `redirect` high in cycle N -> `IP_f` = `redirectIP` in N+1.
- Update latency 1: write in cycle N visible to lookups from N+1; lookup in cycle N sees old contents (unless bypass configured).
- Simultaneous `redirect` and `updateEn`: both take effect.
- Reset mid-redirect or mid-update: reset wins; no BTB write, `IP_f` = `RESET_IP`.
- Critical path: `IP_f` -> BTB read/tag compare -> predictor -> mux -> `IP_f` D input.

## Configuration
- `NIP_BTB_BYPASS_EN` defined: when `updateEn` and `updateIP` == `IP_f` in the same cycle, the lookup uses {hit=1, target=`updateTarget`} instead of array contents.
- Undefined: no bypass; same-cycle lookup sees pre-write entry, per Timing.

## Test plan
- Reset then free-run, no updates -> `IP_f` 0,1,2,3…; `btbHit` = 0 throughout; with `RESET_IP`=16'hFFFE sequence FFFE, FFFF, 0000.
- `updateEn` with `updateIP`=16'h0005, `updateTarget`=16'h0040; later `IP_f`=5 with `prediction`=1 -> `btbHit`=1, next `IP_f`=16'h0040; same with `prediction`=0 -> next `IP_f`=6.
- Alias: train 16'h0005->0040 then 16'h0045->0080 (BTB_IDX=6) -> at `IP_f`=5 `btbHit`=0; at 16'h0045 target 16'h0080.
- `stall` held 3 cycles at `IP_f`=16'h0010 -> `IP_f` stays 16'h0010; `redirect` with `redirectIP`=16'h0100 during stall -> `IP_f`=16'h0100 next cycle.
- Reset asserted with `redirect` and `updateEn` same cycle -> `IP_f`=`RESET_IP`, trained address later misses.
- Same-cycle update at `IP_f`=16'h0020 -> target 16'h0030 with `prediction`=1: bypass build next `IP_f`=16'h0030; non-bypass build 16'h0021.
